// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tone_sequencer
// Brief    : Plays a 16-entry note table as signed square waves on the audio
//            DAC sample path, with a programmable silent gap between notes.
// Revision : 1.0 - initial release
// ============================================================================
module tone_sequencer #(
    parameter int GAP_SAMPLES = 64
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTROBE,
    input  logic        iWR,
    input  logic [3:0]  iWADDR,
    input  logic [23:0] iWDATA,
    input  logic        iSTART,
    input  logic        iSTOP,
    input  logic [4:0]  iLEN,
    input  logic        iLOOP,
    output logic [15:0] oAUDIO,
    output logic        oBUSY,
    output logic        oDONE,
    output logic [3:0]  oNOTE_IDX
);

    localparam logic [15:0] c_GAP     = 16'(GAP_SAMPLES);
    localparam logic        c_HAS_GAP = (GAP_SAMPLES != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [23:0] r_table [16];
    logic [4:0]  r_len;
    logic [3:0]  r_idx;
    logic [7:0]  r_hp;
    logic [3:0]  r_amp;
    logic [11:0] r_dur;
    logic [7:0]  r_phcnt;
    logic        r_phase;
    logic [15:0] r_gap_cnt;
    logic [15:0] r_audio;
    logic        r_done;

    logic [3:0]  w_idx_nxt;
    logic        w_done_nxt;
    logic        w_advance;
    logic        w_start_ok;
    logic        w_last_note;
    logic [23:0] w_entry;
    logic [15:0] w_mag;
    logic [15:0] w_sample;

    assign w_start_ok  = (r_state == S_IDLE) && iSTART && !iSTOP;
    assign w_last_note = ({1'b0, r_idx} + 5'd1) >= r_len;
    assign w_entry     = r_table[r_idx];
    // Amplitude sits just below the sign bit, so 15 peaks at 0x7800.
    assign w_mag       = {1'b0, r_amp, 11'b0};
    assign w_sample    = (r_hp == 8'd0) ? 16'd0 :
                         (r_phase ? w_mag : (~w_mag + 16'd1));

    // Table storage has no reset; entries are undefined until written.
    always_ff @(posedge iCLK) begin
        if (iWR && (r_state == S_IDLE)) begin
            r_table[iWADDR] <= iWDATA;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    if (iLEN != 5'd0) begin
                        w_state_nxt = S_LOAD;
                        w_idx_nxt   = 4'd0;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_LOAD: w_state_nxt = S_PLAY;
            S_PLAY: begin
                if (iSTROBE && (r_dur == 12'd1)) begin
                    if (c_HAS_GAP) begin
                        w_state_nxt = S_GAP;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (iSTROBE && (r_gap_cnt == 16'd1)) begin
                    w_advance = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_advance) begin
            if (!w_last_note) begin
                w_state_nxt = S_LOAD;
                w_idx_nxt   = r_idx + 4'd1;
            end else if (iLOOP) begin
                w_state_nxt = S_LOAD;
                w_idx_nxt   = 4'd0;
            end else begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
        end

        // Stop overrides everything, including a start or a natural finish.
        if (iSTOP) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = r_idx;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_len     <= 5'd0;
            r_idx     <= 4'd0;
            r_hp      <= 8'd0;
            r_amp     <= 4'd0;
            r_dur     <= 12'd0;
            r_phcnt   <= 8'd0;
            r_phase   <= 1'b0;
            r_gap_cnt <= 16'd0;
            r_audio   <= 16'd0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            r_idx  <= w_idx_nxt;
            if (w_start_ok) begin
                r_len <= iLEN;
            end
            case (r_state)
                S_IDLE: r_audio <= 16'd0;
                S_LOAD: begin
                    r_hp    <= w_entry[23:16];
                    r_amp   <= w_entry[15:12];
                    r_dur   <= (w_entry[11:0] == 12'd0) ? 12'd1 : w_entry[11:0];
                    r_phase <= 1'b1;
                    r_phcnt <= w_entry[23:16];
                end
                S_PLAY: begin
                    if (iSTROBE) begin
                        r_audio <= w_sample;
                        r_dur   <= r_dur - 12'd1;
                        if (r_phcnt == 8'd1) begin
                            r_phcnt <= r_hp;
                            r_phase <= ~r_phase;
                        end else begin
                            r_phcnt <= r_phcnt - 8'd1;
                        end
                        if (r_dur == 12'd1) begin
                            r_gap_cnt <= c_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (iSTROBE) begin
                        r_audio   <= 16'd0;
                        r_gap_cnt <= r_gap_cnt - 16'd1;
                    end
                end
                default: ;
            endcase
            if (iSTOP) begin
                r_audio <= 16'd0;
            end
        end
    end

    assign oAUDIO    = r_audio;
    assign oBUSY     = (r_state != S_IDLE);
    assign oDONE     = r_done;
    assign oNOTE_IDX = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tone_sequencer
// Brief    : Directed bench for tone_sequencer with gap=64 and gap=0 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tone_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        strobe = 1'b0;
    logic        wr = 1'b0;
    logic [3:0]  waddr = 4'd0;
    logic [23:0] wdata = 24'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [4:0]  len = 5'd0;
    logic        loop_en = 1'b0;

    logic [15:0] audio_g, audio_z;
    logic        busy_g, busy_z, done_g, done_z;
    logic [3:0]  idx_g, idx_z;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tone_sequencer #(.GAP_SAMPLES(64)) u_dut_gap (
        .iCLK(clk), .iRST(rst), .iSTROBE(strobe), .iWR(wr), .iWADDR(waddr),
        .iWDATA(wdata), .iSTART(start), .iSTOP(stop), .iLEN(len), .iLOOP(loop_en),
        .oAUDIO(audio_g), .oBUSY(busy_g), .oDONE(done_g), .oNOTE_IDX(idx_g)
    );

    tone_sequencer #(.GAP_SAMPLES(0)) u_dut_nogap (
        .iCLK(clk), .iRST(rst), .iSTROBE(strobe), .iWR(wr), .iWADDR(waddr),
        .iWDATA(wdata), .iSTART(start), .iSTOP(stop), .iLEN(len), .iLOOP(loop_en),
        .oAUDIO(audio_z), .oBUSY(busy_z), .oDONE(done_z), .oNOTE_IDX(idx_z)
    );

    typedef struct {
        logic [23:0] entry;
        int          k;
        logic [15:0] audio;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle clock, then a strobe clock; outputs sampled just after the strobe edge.
    task automatic do_strobe();
        strobe = 1'b0;
        tick();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [23:0] d);
        wr = 1'b1; waddr = a; wdata = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] n);
        start = 1'b1; len = n;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dcount;
        logic [15:0] expv;

        vecs[0] = '{24'h04F010, 1, 16'h7800, 1'b1, 1'b0};
        vecs[1] = '{24'h04F010, 4, 16'h7800, 1'b1, 1'b0};
        vecs[2] = '{24'h04F010, 5, 16'h8800, 1'b1, 1'b0};
        vecs[3] = '{24'h04F010, 9, 16'h7800, 1'b1, 1'b0};
        vecs[4] = '{24'h03800A, 3, 16'h4000, 1'b1, 1'b0};
        vecs[5] = '{24'h03800A, 4, 16'hC000, 1'b1, 1'b0};
        vecs[6] = '{24'h00F004, 2, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{24'h020005, 1, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{24'h011002, 2, 16'hF800, 1'b0, 1'b1};
        vecs[9] = '{24'h01F000, 1, 16'h7800, 1'b0, 1'b1};

        rst = 1'b1;
        repeat (3) tick();
        chk("reset audio", {16'd0, audio_g}, 32'd0);
        chk("reset busy", {31'd0, busy_g}, 32'd0);
        chk("reset done", {31'd0, done_g}, 32'd0);
        chk("reset idx", {28'd0, idx_g}, 32'd0);
        chk("reset busy nogap", {31'd0, busy_z}, 32'd0);
        rst = 1'b0;
        tick();

        // Single-note vectors on the gap-less instance
        for (int v = 0; v < 10; v++) begin
            do_stop();
            write_entry(4'd0, vecs[v].entry);
            do_start(5'd1);
            for (int s = 0; s < vecs[v].k; s++) do_strobe();
            chk($sformatf("vec%0d audio", v), {16'd0, audio_z}, {16'd0, vecs[v].audio});
            chk($sformatf("vec%0d busy", v), {31'd0, busy_z}, {31'd0, vecs[v].busy});
            chk($sformatf("vec%0d done", v), {31'd0, done_z}, {31'd0, vecs[v].done});
        end

        // Full note with 64-sample gap
        do_stop();
        write_entry(4'd0, 24'h04F010);
        do_start(5'd1);
        chk("t1 busy after start", {31'd0, busy_g}, 32'd1);
        for (int s = 1; s <= 16; s++) begin
            do_strobe();
            expv = (((s - 1) / 4) % 2 == 0) ? 16'h7800 : 16'h8800;
            chk($sformatf("t1 note s%0d", s), {16'd0, audio_g}, {16'd0, expv});
        end
        dcount = 0;
        for (int s = 1; s <= 64; s++) begin
            do_strobe();
            if (done_g) dcount++;
            if (s == 1 || s == 63) begin
                chk($sformatf("t1 gap s%0d audio", s), {16'd0, audio_g}, 32'd0);
                chk($sformatf("t1 gap s%0d busy", s), {31'd0, busy_g}, 32'd1);
            end
        end
        chk("t1 done at end", {31'd0, done_g}, 32'd1);
        chk("t1 busy at end", {31'd0, busy_g}, 32'd0);
        chk("t1 done count", dcount, 32'd1);
        tick();
        chk("t1 done one cycle", {31'd0, done_g}, 32'd0);

        // Three notes, middle one a rest, no gap
        do_stop();
        write_entry(4'd0, 24'h024008);
        write_entry(4'd1, 24'h00F008);
        write_entry(4'd2, 24'h012008);
        do_start(5'd3);
        dcount = 0;
        for (int s = 1; s <= 24; s++) begin
            do_strobe();
            if (done_z) dcount++;
            if (s == 1) chk("t2 s1", {16'd0, audio_z}, 32'h2000);
            if (s == 3) chk("t2 s3", {16'd0, audio_z}, 32'hE000);
            if (s >= 9 && s <= 16) chk($sformatf("t2 rest s%0d", s), {16'd0, audio_z}, 32'd0);
            if (s == 4)  chk("t2 idx0", {28'd0, idx_z}, 32'd0);
            if (s == 12) chk("t2 idx1", {28'd0, idx_z}, 32'd1);
            if (s == 20) chk("t2 idx2", {28'd0, idx_z}, 32'd2);
            if (s == 17) chk("t2 s17", {16'd0, audio_z}, 32'h1000);
            if (s == 23) chk("t2 busy s23", {31'd0, busy_z}, 32'd1);
        end
        chk("t2 s24", {16'd0, audio_z}, 32'hF000);
        chk("t2 busy end", {31'd0, busy_z}, 32'd0);
        chk("t2 done count", dcount, 32'd1);
        tick();
        chk("t2 audio cleared", {16'd0, audio_z}, 32'd0);

        // Looping, then loop dropped during note 0 of the second pass
        do_stop();
        write_entry(4'd0, 24'h021004);
        write_entry(4'd1, 24'h011004);
        loop_en = 1'b1;
        do_start(5'd2);
        dcount = 0;
        for (int s = 1; s <= 16; s++) begin
            do_strobe();
            if (done_z) dcount++;
            if (s == 8) begin
                chk("t3 loop idx", {28'd0, idx_z}, 32'd0);
                chk("t3 loop busy", {31'd0, busy_z}, 32'd1);
            end
            if (s == 9) loop_en = 1'b0;
            if (s == 12) chk("t3 idx1", {28'd0, idx_z}, 32'd1);
        end
        chk("t3 done end", {31'd0, done_z}, 32'd1);
        chk("t3 done count", dcount, 32'd1);

        // Stop mid-play, then stop and start together
        do_stop();
        write_entry(4'd0, 24'h04F010);
        do_start(5'd1);
        repeat (3) do_strobe();
        chk("t4 playing", {16'd0, audio_z}, 32'h7800);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4 stop busy", {31'd0, busy_z}, 32'd0);
        chk("t4 stop audio", {16'd0, audio_z}, 32'd0);
        chk("t4 stop done", {31'd0, done_z}, 32'd0);
        do_start(5'd1);
        repeat (2) do_strobe();
        stop = 1'b1; start = 1'b1; len = 5'd1;
        tick();
        stop = 1'b0; start = 1'b0;
        chk("t4 stop+start busy", {31'd0, busy_z}, 32'd0);
        chk("t4 stop+start audio", {16'd0, audio_z}, 32'd0);
        tick();
        chk("t4 start ignored", {31'd0, busy_z}, 32'd0);
        chk("t4 no done", {31'd0, done_z}, 32'd0);

        // Write during play is dropped
        do_stop();
        do_start(5'd1);
        repeat (2) do_strobe();
        write_entry(4'd0, 24'h011004);
        do_stop();
        do_start(5'd1);
        do_strobe();
        chk("t5 old data", {16'd0, audio_z}, 32'h7800);

        // Write coinciding with start uses the new data
        do_stop();
        wr = 1'b1; waddr = 4'd0; wdata = 24'h012004;
        start = 1'b1; len = 5'd1;
        tick();
        wr = 1'b0; start = 1'b0;
        do_strobe();
        chk("t6 new s1", {16'd0, audio_z}, 32'h1000);
        do_strobe();
        chk("t6 new s2", {16'd0, audio_z}, 32'hF000);

        // Zero-length start
        do_stop();
        do_start(5'd0);
        chk("t7 len0 busy", {31'd0, busy_z}, 32'd0);
        chk("t7 len0 done", {31'd0, done_z}, 32'd1);
        tick();
        chk("t7 len0 done drop", {31'd0, done_z}, 32'd0);

        // Asynchronous reset in the gap of note 1
        do_stop();
        write_entry(4'd0, 24'h04F002);
        write_entry(4'd1, 24'h04F002);
        do_start(5'd2);
        repeat (78) do_strobe();
        chk("t8 pre idx", {28'd0, idx_g}, 32'd1);
        chk("t8 pre busy", {31'd0, busy_g}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t8 rst busy", {31'd0, busy_g}, 32'd0);
        chk("t8 rst idx", {28'd0, idx_g}, 32'd0);
        chk("t8 rst audio", {16'd0, audio_g}, 32'd0);
        chk("t8 rst done", {31'd0, done_g}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (3) do_strobe();
        chk("t8 no resume", {31'd0, busy_g}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tone_sequencer.md
# tone_sequencer

Sequencer that plays a programmed melody through the audio DAC path. It holds a 16-entry note table (half-period, amplitude, duration) and steps through it. For each entry it generates a signed square wave at the audio sample rate, with a programmable silent gap between notes. It sits between the host/switch logic and the AUDIO_DAC_ADC left/right sample inputs, replacing the free-running square-wave generator.

## Interface
- GAP_SAMPLES, 64: silent samples inserted after every note; 0 means no gap.
- iCLK  in  1  system clock (CLOCK_50 domain).
- iRST  in  1  asynchronous active-high reset.
- iSTROBE  in  1  one-cycle pulse per audio sample (synchronised DACLRCK rising edge); all audio timing counts strobes.
- iWR  in  1  table write enable.
- iWADDR  in  4  table write address.
- iWDATA  in  24  entry: [23:16] half_period (samples, 0 = rest), [15:12] amplitude, [11:0] duration (samples).
- iSTART  in  1  one-cycle start pulse.
- iSTOP  in  1  one-cycle stop pulse.
- iLEN  in  5  notes to play, 0..16; sampled on accepted iSTART.
- iLOOP  in  1  level; when high, the sequence restarts at entry 0 after the last note.
- oAUDIO  out  16  signed sample to the DAC (drive L and R).
- oBUSY  out  1  high in any state other than IDLE.
- oDONE  out  1  one-cycle pulse at natural end of sequence.
- oNOTE_IDX  out  4  index of the entry currently loaded/playing.

## Operation
- States: IDLE, LOAD, PLAY, GAP.
- Table writes are accepted only in IDLE, including the cycle iSTART is accepted. Writes in other states are dropped.
- IDLE:
  - iSTART with iLEN≠0: latch len, idx←0, go to LOAD.
  - iSTART with iLEN=0: stay in IDLE, pulse oDONE next cycle.
  - iSTART while not IDLE is ignored.
- LOAD (exactly 1 clock, not strobe-gated): register entry[idx] into hp, amp, dur; phase←high; phcnt←hp. Duration 0 is treated as 1. Go to PLAY.
- PLAY, on each iSTROBE:
  - oAUDIO ← 0 if hp=0; else +{1'b0,amp,11'b0} when phase high, or its two's-complement negation when phase low.
  - phcnt decrements. When it was 1: reload to hp and toggle phase.
  - dur decrements. The strobe on which dur was 1 is the last note sample; go to GAP, or straight to note-advance if GAP_SAMPLES=0.
- GAP: oAUDIO=0. Count GAP_SAMPLES strobes, then note-advance.
- Note-advance:
  - idx<len-1: idx+1 → LOAD.
  - Otherwise, iLOOP=1: idx←0 → LOAD, no oDONE.
  - Otherwise: → IDLE, oDONE pulse, oAUDIO←0.
- iSTOP in any state: next clock → IDLE, oAUDIO←0, no oDONE. iSTOP beats iSTART in the same cycle.
- Amplitude 15 gives ±0x7800; the result never overflows 16 bits.
- A square tone has period 2·hp samples and starts on the high half.

## Timing
- Reset values (all outputs): oAUDIO=0, oBUSY=0, oDONE=0, oNOTE_IDX=0, state IDLE. Table contents are not reset; they are undefined until written.
- Start handshake:
  - iSTART at clock n: LOAD at n+1, PLAY at n+2; oBUSY is high from n+1.
  - First audible sample is registered on the first iSTROBE at or after n+2. A strobe coinciding with LOAD is not counted.
- oAUDIO is registered and updates only on iSTROBE cycles in PLAY/GAP; it is forced to 0 on the clock after IDLE entry.
- Each note costs exactly dur strobes, plus GAP_SAMPLES strobes, plus 1 clock for LOAD.
- oDONE rises on the clock after the last gap strobe, together with oBUSY falling.
- oNOTE_IDX updates on entry to LOAD.
- Reset asserted mid-sequence: everything returns to reset values immediately. The sequence does not resume after reset release.

## Test plan
- Write entry0={hp=4, amp=15, dur=16}, iLEN=1, GAP=64, iSTART:
  - oAUDIO over 16 strobes reads +0x7800 ×4, −0x7800 ×4, and repeats.
  - Then 64 zero samples, oDONE pulse, oBUSY=0.
- Three entries with durations 8/8/8, second entry hp=0 (rest), GAP_SAMPLES=0:
  - 24 strobes total; samples 9–16 are 0; oNOTE_IDX steps 0,1,2; single oDONE.
- iLOOP=1, iLEN=2:
  - After note 1, oNOTE_IDX returns to 0 with no oDONE.
  - Drop iLOOP during note 0: sequence ends after note 1 with oDONE.
- iSTOP mid-PLAY, also iSTOP+iSTART in the same cycle:
  - IDLE next clock, oAUDIO=0, no oDONE; the simultaneous iSTART is ignored.
- iWR to entry0 during PLAY: the write is dropped, and the replay after restart uses the old data.
- Write and iSTART in the same cycle: the new data plays.
- iLEN=0 start: oBUSY stays 0 and oDONE pulses one clock later.
- Async iRST mid-GAP: all outputs are 0 within the same cycle.
